// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate_bist self-test controller.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NUM_VEC = 4;

  // Expected output indexed by {a,b}
  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;

endpackage

// File: rtl/gate_bist_settle_cnt.sv
// Loadable down-counter pacing how long each test vector is held.
module gate_bist_settle_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_bist.sv
// Built-in self test for a 2-input gate: walks {a,b} through 00..11 and checks gate_y.
// Optional mismatch counter output err_cnt when GATE_BIST_ERRCNT_EN is defined.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TRUTH_AND,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
`ifdef GATE_BIST_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  state_t     state, state_d;
  logic [1:0] vec, vec_d;
  logic       busy_d, done_d, pass_d;
  logic [3:0] fail_d;
  logic       cnt_load, cnt_zero, mis_evt;

  gate_bist_settle_cnt #(.W(4)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (state == RUN),
    .load_val (4'(SETTLE - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= '0;
    end else begin
      state    <= state_d;
      vec      <= vec_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      fail_vec <= fail_d;
    end
  end

  always_comb begin
    state_d  = state;
    vec_d    = vec;
    busy_d   = busy;
    done_d   = 1'b0;
    pass_d   = pass;
    fail_d   = fail_vec;
    cnt_load = 1'b0;
    mis_evt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          vec_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          cnt_load = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
          vec_d   = '0;
        end else if (cnt_zero) begin
          // Case inequality so an X/Z on gate_y is reported as a mismatch
          mis_evt  = (gate_y !== TRUTH[vec]);
          cnt_load = 1'b1;
          if (mis_evt) fail_d[vec] = 1'b1;
          if (vec == 2'(NUM_VEC - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (fail_d == '0);
            vec_d   = '0;
          end else begin
            vec_d = vec + 2'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gate_a = vec[1];
  assign gate_b = vec[0];

`ifdef GATE_BIST_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (mis_evt && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter TRUTH, 4 bits, default 4'b1000, expected gate output indexed by vector {a,b} (default = 2-input AND).
REQ-002 Parameter SETTLE, integer, default 2, range 1..15, cycles each vector is held before gate_y is sampled.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a self-test run; sampled only in IDLE.
REQ-006 abort  input  1  terminate a run in progress.
REQ-007 gate_y  input  1  output of the gate under test.
REQ-008 gate_a  output  1  gate input A, registered.
REQ-009 gate_b  output  1  gate input B, registered.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  one-cycle pulse at run completion.
REQ-012 pass  output  1  result of the last completed run; high only if all 4 vectors matched.
REQ-013 fail_vec  output  4  bit v set when vector v mismatched in the last run.

Function
REQ-014 FSM states: IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after vector 3 is sampled, DONE->IDLE unconditionally after 1 cycle.
REQ-015 Vector v (0..3) drives {gate_a,gate_b}=v; vectors run in ascending order, v=0 first.
REQ-016 Edge E0 = edge where start is sampled in IDLE: busy<=1, {gate_a,gate_b}<=0, fail_vec<=0, pass<=0, settle counter<=SETTLE-1.
REQ-017 Vector v is applied at edge E0+v*SETTLE and gate_y is sampled at edge E0+(v+1)*SETTLE; the next vector is applied on that same edge.
REQ-018 Mismatch = gate_y !== TRUTH[v]; X or Z on gate_y counts as mismatch; a mismatch sets fail_vec[v].
REQ-019 At edge E0+4*SETTLE: state<=DONE, done<=1, busy<=0, pass<=(final fail_vec==0), {gate_a,gate_b}<=0.
REQ-020 Default SETTLE=2: done high in the cycle after edge E0+8.
REQ-021 pass and fail_vec hold until the next start or reset.
REQ-022 start while busy or in DONE is ignored; no queuing.
REQ-023 abort in RUN: next edge returns to IDLE, busy<=0, done stays 0, pass<=0, gate inputs<=0, fail_vec retains partial results.
REQ-024 abort and start in the same IDLE cycle: abort wins, no run starts.
REQ-025 abort in IDLE or DONE has no effect.

Reset
REQ-026 rst_n low asynchronously forces state IDLE and gate_a, gate_b, busy, done, pass, fail_vec and settle counter to 0.
REQ-027 Reset mid-run discards the run; no done pulse follows reset release.

Configuration
REQ-028 Macro GATE_BIST_ERRCNT_EN defined: extra output err_cnt, 8 bits, counts every mismatch across runs, saturates at 255, cleared only by reset.
REQ-029 Macro undefined: err_cnt port and counter are absent; all other behaviour identical.

Structure
REQ-030 Shared package gate_bist_pkg holds the state enum typedef (IDLE, RUN, DONE), NUM_VEC=4 and the default TRUTH constants for AND, OR, XOR, NAND.
REQ-031 One sub-module, gate_bist_settle_cnt: a loadable down-counter that flags zero and paces vector sampling.

Verification
REQ-032 Good AND gate, TRUTH=4'b1000, SETTLE=2, pulse start -> gate_a/gate_b step 00,01,10,11 every 2 cycles; done one cycle after E0+8; pass=1, fail_vec=0000.
REQ-033 gate_y stuck at 1 -> pass=0, fail_vec=0111; with GATE_BIST_ERRCNT_EN err_cnt=3, then 6 after a second run.
REQ-034 abort asserted 3 cycles after start -> busy low next cycle, no done pulse, pass=0, gate_a=gate_b=0; a new start then runs normally to pass=1.
REQ-035 rst_n dropped mid-run, asynchronously -> all outputs 0 immediately; after release, start is required before any activity.
REQ-036 start held high continuously, SETTLE=1 -> back-to-back runs 6 cycles apart (4 RUN, 1 DONE, 1 IDLE); start during RUN is ignored.
REQ-037 gate_y driven X on vector 2 with TRUTH=4'b1000 -> fail_vec=0100, pass=0.
